// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared types for the bit-serial subtractor controller.
package serial_subtractor_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Bit counter width; a 1-bit counter is the floor even for tiny operands.
  function automatic int count_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_ctrl_cell.sv
// One-bit subtractor datapath: a full subtractor built from two half subtractors.
module half_subtractor_cell (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);
  assign d = x ^ y;
  assign b = ~x & y;
endmodule

module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;

  half_subtractor_cell u_hs0 (.x(x),  .y(y),   .d(d1), .b(b1));
  half_subtractor_cell u_hs1 (.x(d1), .y(bin), .d(d),  .b(b2));

  assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A - B: one full subtractor cell reused LSB first, borrow held in a flop.
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-2:0] res_sr_reg;
  logic             borrow_reg;
  logic [CW-1:0]    count_reg;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] res_next;

  full_subtractor_cell u_cell (
    .x    (a_sr_reg[0]),
    .y    (b_sr_reg[0]),
    .bin  (borrow_reg),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // The result bit enters at the MSB; after WIDTH shifts bit 0 of res_next is the LSB.
  assign res_next = {cell_d, res_sr_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      res_sr_reg <= '0;
      borrow_reg <= 1'b0;
      count_reg  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr_reg   <= a;
            b_sr_reg   <= b;
            borrow_reg <= 1'b0;
            count_reg  <= '0;
            busy       <= 1'b1;
            state_reg  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          res_sr_reg <= res_next[WIDTH-1:1];
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          borrow_reg <= cell_bout;
          count_reg  <= count_reg + 1'b1;
          if (count_reg == LAST_BIT) begin
            diff       <= res_next;
            borrow_out <= cell_bout;
            done       <= 1'b1;
            state_reg  <= S_DONE;
          end
        end
        default: begin
          // S_DONE: one-cycle result pulse, then back to IDLE regardless of start.
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl (WIDTH=8): vectors, corner sequences, random sweep.
module tb_serial_subtractor_ctrl;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int errors = 0;
  int checks = 0;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bo;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference: unsigned modular subtraction and a plain magnitude compare.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    return x - y;
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x < y);
  endfunction

  // Runs one operation from IDLE; counts edges from start (accepting edge = 1) to done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input string name,
                        input bit verbose);
    int n;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({name, " latency"}, n, W + 1);
    chk({name, " diff"}, diff, ref_diff(ta, tb_v));
    chk({name, " borrow_out"}, borrow_out, ref_borrow(ta, tb_v));
    if (verbose)
      $display("op %s: a=%0d b=%0d diff=%0d borrow_out=%0d edges=%0d", name, ta, tb_v, diff, borrow_out, n);
    @(posedge clk);
    @(negedge clk);
    chk({name, " done single pulse"}, done, 1'b0);
  endtask

  initial begin
    logic [W-1:0] ops_a[3];
    logic [W-1:0] ops_b[3];
    logic [W-1:0] last_diff;
    int           done_cnt;
    logic [W-1:0] seen_diff;

    vecs[0] = '{a: 8'd200, b: 8'd55,  diff: 8'd145, bo: 1'b0};
    vecs[1] = '{a: 8'd5,   b: 8'd10,  diff: 8'd251, bo: 1'b1};
    vecs[2] = '{a: 8'd0,   b: 8'd255, diff: 8'd1,   bo: 1'b1};
    vecs[3] = '{a: 8'd0,   b: 8'd0,   diff: 8'd0,   bo: 1'b0};
    vecs[4] = '{a: 8'd255, b: 8'd255, diff: 8'd0,   bo: 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset diff", diff, '0);
    chk("reset borrow_out", borrow_out, 1'b0);
    rst_n = 1'b1;

    // Table vectors, with constants cross-checking the reference model.
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("vec%0d table diff", i), ref_diff(vecs[i].a, vecs[i].b), vecs[i].diff);
      chk($sformatf("vec%0d table bo", i), ref_borrow(vecs[i].a, vecs[i].b), vecs[i].bo);
      run_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), 1'b1);
    end

    // Start pulsed again while busy must be ignored.
    @(negedge clk);
    start = 1'b1; a = 8'd9; b = 8'd4;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b1; a = 8'd1; b = 8'd2;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    done_cnt = 0; seen_diff = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (done) begin done_cnt++; seen_diff = diff; end
    end
    chk("busy-start done count", done_cnt, 1);
    chk("busy-start diff", seen_diff, 8'd5);
    $display("op busy-start: dones=%0d diff=%0d", done_cnt, seen_diff);

    // Reset mid-operation aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; a = 8'd100; b = 8'd3;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    chk("abort busy in reset", busy, 1'b0);
    chk("abort diff in reset", diff, '0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort done count", done_cnt, 0);
    chk("abort busy", busy, 1'b0);
    chk("abort diff", diff, '0);
    $display("op abort: dones=%0d busy=%0d diff=%0d", done_cnt, busy, diff);
    run_op(8'd77, 8'd33, "after-abort", 1'b1);

    // Streaming with start held: accept edges fall every W+2 edges.
    ops_a[0] = 8'd50;  ops_b[0] = 8'd20;
    ops_a[1] = 8'd3;   ops_b[1] = 8'd200;
    ops_a[2] = 8'd128; ops_b[2] = 8'd127;
    last_diff = '0;
    @(negedge clk);
    start = 1'b1; a = ops_a[0]; b = ops_b[0];
    for (int n = 1; n <= 3 * (W + 2); n++) begin
      int  idx;
      logic exp_done;
      @(posedge clk); @(negedge clk);
      idx = (n - 1) / (W + 2);
      exp_done = ((n % (W + 2)) == W + 1);
      chk($sformatf("stream done n=%0d", n), done, exp_done);
      if (exp_done) begin
        last_diff = ref_diff(ops_a[idx], ops_b[idx]);
        chk($sformatf("stream diff op%0d", idx), diff, last_diff);
        chk($sformatf("stream bo op%0d", idx), borrow_out, ref_borrow(ops_a[idx], ops_b[idx]));
        $display("op stream%0d: a=%0d b=%0d diff=%0d borrow_out=%0d", idx, ops_a[idx], ops_b[idx], diff, borrow_out);
      end else if (n > W + 1) begin
        chk($sformatf("stream diff hold n=%0d", n), diff, last_diff);
      end
      if (n == 3 * (W + 2) - 1) start = 1'b0;
      if (n / (W + 2) < 3) begin
        a = ops_a[n / (W + 2)]; b = ops_b[n / (W + 2)];
      end else begin
        a = W'($urandom); b = W'($urandom);
      end
    end
    start = 1'b0;
    repeat (2) @(posedge clk);

    // Random sweep against the arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, $sformatf("rand%0d", i), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
